// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and width helpers for the streaming 2D
//                convolution engine (state encoding, counter/address widths,
//                default accumulator width).
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Engine states; explicit 3-bit encoding keeps the state register width fixed
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IMG = 3'd1,
        LOAD_KER = 3'd2,
        COMPUTE  = 3'd3,
        EMIT     = 3'd4
    } state_t;

    // Bits needed to hold the value maxVal itself (used for dimension ports)
    function automatic int cntWidth(input int maxVal);
        return $clog2(maxVal + 1);
    endfunction

    // Bits needed to address depth entries (never less than one bit)
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Accumulator wide enough that a full MAX_K x MAX_K window cannot overflow
    function automatic int accWidth(input int dataW, input int maxK);
        return 2 * dataW + $clog2(maxK * maxK);
    endfunction

    localparam int c_defDataW = 8;
    localparam int c_defMaxK  = 4;
    localparam int c_defAccW  = accWidth(c_defDataW, c_defMaxK);

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mac
//  Description : Registered multiply-accumulate. The product is formed signed
//                or unsigned, extended to ACC_W and added to the accumulator.
//                i_clear together with i_enable starts a new sum with the
//                current product, so no dead cycle is needed between windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic              i_signedMode,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prodS;
    logic        [2*DATA_W-1:0] w_prodU;
    logic        [ACC_W-1:0]    w_prodExt;
    logic        [ACC_W-1:0]    r_acc;

    assign w_prodS   = $signed(i_a) * $signed(i_b);
    assign w_prodU   = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign w_prodExt = i_signedMode ? ACC_W'(w_prodS) : ACC_W'(w_prodU);

    // Accumulate one product per enabled cycle; clear restarts the sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= (i_clear ? '0 : r_acc) + w_prodExt;
        end else if (i_clear) begin
            r_acc <= '0;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : conv2d_stream
//  Description : Streaming valid-mode 2D convolution. Loads an image then a
//                kernel (row-major) over one valid/ready channel, computes each
//                output window with one MAC per cycle and emits results
//                row-major over a valid/ready channel with a frame-last flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_IN = 16,
    parameter int MAX_K  = 4,
    parameter int MAX_S  = 3,
    parameter int ACC_W  = accWidth(DATA_W, MAX_K)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [cntWidth(MAX_IN)-1:0] in_rows,
    input  logic [cntWidth(MAX_IN)-1:0] in_cols,
    input  logic [cntWidth(MAX_K)-1:0]  ker_rows,
    input  logic [cntWidth(MAX_K)-1:0]  ker_cols,
    input  logic [cntWidth(MAX_S)-1:0]  stride,
    input  logic                        signed_mode,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int c_inW      = cntWidth(MAX_IN);
    localparam int c_kW       = cntWidth(MAX_K);
    localparam int c_sW       = cntWidth(MAX_S);
    localparam int c_imgDepth = MAX_IN * MAX_IN;
    localparam int c_kerDepth = MAX_K * MAX_K;
    localparam int c_imgAw    = addrWidth(c_imgDepth);
    localparam int c_kerAw    = addrWidth(c_kerDepth);
    // Wide enough for window origin + stride + kernel extent
    localparam int c_sumW     = cntWidth(MAX_IN + MAX_S + MAX_K);

    state_t            r_state;
    logic [c_inW-1:0]  r_inRows, r_inCols;
    logic [c_kW-1:0]   r_kerRows, r_kerCols;
    logic [c_sW-1:0]   r_stride;
    logic              r_signed;
    logic [c_inW-1:0]  r_row, r_col;      // image load position
    logic [c_kW-1:0]   r_kr, r_kc;        // kernel position (load and compute)
    logic [c_inW-1:0]  r_baseR, r_baseC;  // top-left of current output window
    logic              r_inReady, r_outValid, r_outLast, r_busy, r_done, r_err;

    logic [DATA_W-1:0] r_img [c_imgDepth];
    logic [DATA_W-1:0] r_ker [c_kerDepth];

    logic              w_cfgOk;
    logic              w_accept;
    logic [c_imgAw-1:0] w_loadImgAddr, w_pixAddr;
    logic [c_kerAw-1:0] w_kerAddr;
    logic [c_inW-1:0]  w_pixRow, w_pixCol;
    logic              w_colEnd, w_rowEnd, w_kcEnd, w_krEnd;
    logic              w_colLast, w_rowLast, w_winFirst, w_macEn;
    logic [ACC_W-1:0]  w_acc;

    // A configuration is usable only if every window fits inside the image
    assign w_cfgOk = (in_rows != '0) && (in_cols != '0)
                  && (ker_rows != '0) && (ker_cols != '0)
                  && (int'(in_rows) <= MAX_IN) && (int'(in_cols) <= MAX_IN)
                  && (int'(ker_rows) <= MAX_K) && (int'(ker_cols) <= MAX_K)
                  && (int'(ker_rows) <= int'(in_rows))
                  && (int'(ker_cols) <= int'(in_cols))
                  && (stride != '0) && (int'(stride) <= MAX_S);

    assign w_accept = in_valid && r_inReady;

    assign w_colEnd = (r_col == r_inCols - 1'b1);
    assign w_rowEnd = (r_row == r_inRows - 1'b1);
    assign w_kcEnd  = (r_kc == r_kerCols - 1'b1);
    assign w_krEnd  = (r_kr == r_kerRows - 1'b1);

    // Next window would run past the right/bottom edge -> current one is last
    assign w_colLast = (c_sumW'(r_baseC) + c_sumW'(r_stride) + c_sumW'(r_kerCols))
                       > c_sumW'(r_inCols);
    assign w_rowLast = (c_sumW'(r_baseR) + c_sumW'(r_stride) + c_sumW'(r_kerRows))
                       > c_sumW'(r_inRows);

    assign w_loadImgAddr = c_imgAw'(r_row) * c_imgAw'(MAX_IN) + c_imgAw'(r_col);
    assign w_kerAddr     = c_kerAw'(r_kr) * c_kerAw'(MAX_K) + c_kerAw'(r_kc);
    assign w_pixRow      = r_baseR + c_inW'(r_kr);
    assign w_pixCol      = r_baseC + c_inW'(r_kc);
    assign w_pixAddr     = c_imgAw'(w_pixRow) * c_imgAw'(MAX_IN) + c_imgAw'(w_pixCol);

    assign w_macEn    = (r_state == COMPUTE);
    assign w_winFirst = (r_kr == '0) && (r_kc == '0);

    // Sample buffers; contents need no reset since every frame reloads them
    always_ff @(posedge clk) begin
        if (w_accept && (r_state == LOAD_IMG)) begin
            r_img[w_loadImgAddr] <= in_data;
        end
        if (w_accept && (r_state == LOAD_KER)) begin
            r_ker[w_kerAddr] <= in_data;
        end
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_macEn && w_winFirst),
        .i_enable     (w_macEn),
        .i_signedMode (r_signed),
        .i_a          (r_img[w_pixAddr]),
        .i_b          (r_ker[w_kerAddr]),
        .o_acc        (w_acc)
    );

    // Control FSM: load image, load kernel, then alternate compute/emit per window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_inRows   <= '0;
            r_inCols   <= '0;
            r_kerRows  <= '0;
            r_kerCols  <= '0;
            r_stride   <= '0;
            r_signed   <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_kr       <= '0;
            r_kc       <= '0;
            r_baseR    <= '0;
            r_baseC    <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_cfgOk) begin
                            r_inRows  <= in_rows;
                            r_inCols  <= in_cols;
                            r_kerRows <= ker_rows;
                            r_kerCols <= ker_cols;
                            r_stride  <= stride;
                            r_signed  <= signed_mode;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_kr      <= '0;
                            r_kc      <= '0;
                            r_inReady <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= LOAD_IMG;
                        end else begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                LOAD_IMG: begin
                    if (w_accept) begin
                        if (w_colEnd) begin
                            r_col <= '0;
                            if (w_rowEnd) begin
                                r_row   <= '0;
                                r_state <= LOAD_KER;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                LOAD_KER: begin
                    if (w_accept) begin
                        if (w_kcEnd) begin
                            r_kc <= '0;
                            if (w_krEnd) begin
                                r_kr      <= '0;
                                r_baseR   <= '0;
                                r_baseC   <= '0;
                                r_inReady <= 1'b0;
                                r_state   <= COMPUTE;
                            end else begin
                                r_kr <= r_kr + 1'b1;
                            end
                        end else begin
                            r_kc <= r_kc + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (w_kcEnd) begin
                        r_kc <= '0;
                        if (w_krEnd) begin
                            r_kr       <= '0;
                            r_outValid <= 1'b1;
                            r_outLast  <= w_colLast && w_rowLast;
                            r_state    <= EMIT;
                        end else begin
                            r_kr <= r_kr + 1'b1;
                        end
                    end else begin
                        r_kc <= r_kc + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        if (r_outLast) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            if (w_colLast) begin
                                r_baseC <= '0;
                                r_baseR <= r_baseR + c_inW'(r_stride);
                            end else begin
                                r_baseC <= r_baseC + c_inW'(r_stride);
                            end
                            r_state <= COMPUTE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = w_acc;
    assign out_last  = r_outLast;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_conv2d_stream
//  Description : Self-checking bench for conv2d_stream. Stimulus pushes the
//                reference convolution results into a queue; a monitor pops
//                and compares on every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_stream;

    localparam int DATA_W = 8;
    localparam int MAX_IN = 16;
    localparam int MAX_K  = 4;
    localparam int MAX_S  = 3;
    localparam int ACC_W  = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [4:0]        in_rows, in_cols;
    logic [2:0]        ker_rows, ker_cols;
    logic [1:0]        stride;
    logic              signed_mode;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_last, busy, done, err;

    always #5 clk = ~clk;

    conv2d_stream #(
        .DATA_W (DATA_W),
        .MAX_IN (MAX_IN),
        .MAX_K  (MAX_K),
        .MAX_S  (MAX_S),
        .ACC_W  (ACC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_rows     (in_rows),
        .in_cols     (in_cols),
        .ker_rows    (ker_rows),
        .ker_cols    (ker_cols),
        .stride      (stride),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int checks   = 0;
    int failures = 0;
    int nResults = 0;
    int readyMode = 0;   // 0 always ready, 1 random, 2 stall 10 cycles per result
    logic [ACC_W:0] expQ[$];  // {last, data}
    int imgA[256];
    int kerA[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic longint sval(input int v, input bit sg);
        return (sg && v >= 128) ? longint'(v - 256) : longint'(v);
    endfunction

    // Reference: direct valid-mode convolution over row-major tb arrays
    task automatic buildExpected(input int r, input int c, input int kr, input int kc,
                                 input int s, input bit sg, output int cnt);
        int orows, ocols;
        longint sum;
        logic [63:0] t;
        logic [ACC_W:0] e;
        orows = (r - kr) / s + 1;
        ocols = (c - kc) / s + 1;
        cnt = orows * ocols;
        for (int i = 0; i < orows; i++) begin
            for (int j = 0; j < ocols; j++) begin
                sum = 0;
                for (int a = 0; a < kr; a++)
                    for (int b = 0; b < kc; b++)
                        sum += sval(imgA[(i*s + a)*c + j*s + b], sg) * sval(kerA[a*kc + b], sg);
                t = sum;
                e = {(i == orows-1) && (j == ocols-1), t[ACC_W-1:0]};
                expQ.push_back(e);
            end
        end
    endtask

    // Output-side ready generator
    initial begin
        int stallCnt;
        stallCnt = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid) begin
                        if (stallCnt < 10) begin
                            out_ready = 1'b0;
                            stallCnt++;
                        end else begin
                            out_ready = 1'b1;
                            stallCnt = 0;
                        end
                    end else begin
                        out_ready = 1'b0;
                        stallCnt = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: compare each accepted result, and hold stability while stalled
    initial begin
        logic           holdValid;
        logic [ACC_W-1:0] heldData;
        logic [ACC_W:0] e;
        holdValid = 1'b0;
        heldData  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holdValid = 1'b0;
            end else if (out_valid) begin
                if (holdValid) check("stall_hold_data", out_data, heldData);
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result actual=0x%0h required=none", out_data);
                    end else begin
                        e = expQ.pop_front();
                        check("result_data", out_data, e[ACC_W-1:0]);
                        check("result_last", out_last, e[ACC_W]);
                    end
                    nResults++;
                    holdValid = 1'b0;
                end else begin
                    holdValid = 1'b1;
                    heldData  = out_data;
                end
            end else begin
                if (holdValid) check("stall_hold_valid", out_valid, 1);
                holdValid = 1'b0;
            end
        end
    end

    task automatic feedWord(input logic [DATA_W-1:0] w);
        int n;
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic setCfg(input int r, input int c, input int kr, input int kc,
                          input int s, input bit sg);
        in_rows     = 5'(r);
        in_cols     = 5'(c);
        ker_rows    = 3'(kr);
        ker_cols    = 3'(kc);
        stride      = 2'(s);
        signed_mode = sg;
    endtask

    // One complete legal frame; called at posedge+1
    task automatic runFrame(input int r, input int c, input int kr, input int kc,
                            input int s, input bit sg, input int rmode);
        int n, expCount, resBase;
        bit gotDone;
        readyMode = rmode;
        buildExpected(r, c, kr, kc, s, sg, expCount);
        resBase = nResults;
        setCfg(r, c, kr, kc, s, sg);
        start = 1'b1;
        @(posedge clk); #1;
        check("busy_after_start", busy, 1);
        // scramble config and keep start high while loading: both must be ignored
        in_rows = 5'($urandom); in_cols = 5'($urandom);
        ker_rows = 3'($urandom); ker_cols = 3'($urandom);
        stride = 2'($urandom); signed_mode = ~sg;
        for (int i = 0; i < r*c; i++) feedWord(DATA_W'(imgA[i]));
        start = 1'b0;
        for (int i = 0; i < kr*kc; i++) feedWord(DATA_W'(kerA[i]));
        in_valid = 1'b0;
        check("in_ready_drop", in_ready, 0);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_latency", n, kr*kc + 1);
        n = 0;
        gotDone = 1'b0;
        while (n < 20000 && !gotDone) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                gotDone = 1'b1;
                check("done_err_low", err, 0);
            end
        end
        check("done_seen", gotDone, 1);
        check("busy_after_done", busy, 0);
        check("result_count", nResults - resBase, expCount);
        check("queue_empty", expQ.size(), 0);
        expQ.delete();
        @(posedge clk); #1;
    endtask

    task automatic checkAllZero(input string nm);
        check(nm, {in_ready, out_valid, out_last, busy, done, err, out_data}, 0);
    endtask

    task automatic loadDirected();
        int row0[5];
        int kx[9];
        row0 = '{1, 0, 2, 3, 4};
        kx   = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 25; i++) imgA[i] = (i < 5) ? row0[i] : i;
        for (int i = 0; i < 9; i++) kerA[i] = kx[i];
    endtask

    // Illegal configurations: err+done one cycle after start, no input consumed
    task automatic illegalCase(input int r, input int c, input int kr, input int kc, input int s);
        setCfg(r, c, kr, kc, s, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_err", err, 1);
        check("illegal_done", done, 1);
        check("illegal_busy", busy, 0);
        check("illegal_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("illegal_pulse_width", {err, done}, 0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_in_ready_later", {in_ready, out_valid, busy}, 0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr, cc, kr, kc, ss;
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        setCfg(0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk); #1;

        loadDirected();
        runFrame(5, 5, 3, 3, 1, 1'b0, 0);
        runFrame(5, 5, 3, 3, 2, 1'b0, 1);

        for (int i = 0; i < 4; i++) imgA[i] = 255;
        kerA[0] = 2;
        runFrame(2, 2, 1, 1, 1, 1'b1, 1);

        loadDirected();
        runFrame(5, 5, 3, 3, 1, 1'b0, 2);

        illegalCase(5, 5, 6, 3, 1);
        illegalCase(5, 5, 3, 3, 0);
        illegalCase(0, 5, 1, 1, 1);
        illegalCase(4, 3, 2, 4, 1);
        illegalCase(17, 17, 2, 2, 1);

        // Abort a frame mid-compute, then run a fresh frame
        loadDirected();
        readyMode = 0;
        setCfg(5, 5, 3, 3, 1, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 25; i++) feedWord(DATA_W'(imgA[i]));
        for (int i = 0; i < 9; i++) feedWord(DATA_W'(kerA[i]));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("abort_reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("abort_reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) imgA[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) kerA[i] = int'($urandom_range(0, 255));
        runFrame(4, 4, 2, 2, 1, 1'b1, 0);

        // Randomized legal frames
        for (int f = 0; f < 4; f++) begin
            rr = int'($urandom_range(1, MAX_IN));
            cc = int'($urandom_range(1, MAX_IN));
            kr = int'($urandom_range(1, (rr < MAX_K) ? rr : MAX_K));
            kc = int'($urandom_range(1, (cc < MAX_K) ? cc : MAX_K));
            ss = int'($urandom_range(1, MAX_S));
            for (int i = 0; i < rr*cc; i++) imgA[i] = int'($urandom_range(0, 255));
            for (int i = 0; i < kr*kc; i++) kerA[i] = int'($urandom_range(0, 255));
            runFrame(rr, cc, kr, kc, ss, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
